output_display: RTL and testbench

Output display stage for the CPU datapath. Each result byte strobed out by the core is captured, converted to three BCD digits by a sequential double-dabble converter, and shown on a 4-digit multiplexed seven-segment display. A single-entry pending buffer absorbs results that arrive while a conversion is in progress.

---
 rtl/output_display.sv | 272 +++++++++++++++++++++++++++
 tb/tb_output_display.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_display.sv
// output_display: captures result bytes from the core, converts each one to
// three BCD digits with an 8-cycle sequential double-dabble, and scans the
// result onto a 4-digit multiplexed seven-segment display (an[0] = ones,
// an[3] = sign). A single-entry pending buffer holds the most recent byte
// that arrives while a conversion is running.
//
// Optional feature macro: SIGNED_DISPLAY_EN
//   defined   : data_in is two's complement; the magnitude is converted and
//               digit 3 shows a minus sign for negative bytes.
//   undefined : data_in is unsigned 0..255; digit 3 is always blank.
//
// REFRESH_DIV is the number of clock cycles each digit is driven and must
// be at least 2.
`timescale 1ns/1ps

module output_display #(
    parameter int REFRESH_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic [7:0] value_out,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Double-dabble correction: a BCD nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
    endfunction

    // Decimal digit to segment pattern {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

`ifdef SIGNED_DISPLAY_EN
    // Magnitude of a two's complement byte. -128 wraps to 8'h80, which
    // reads back as 128 when treated as unsigned, so it displays correctly.
    function automatic logic [7:0] magnitude(input logic signed [7:0] v);
        logic signed [7:0] neg;
        neg = -v;
        return v[7] ? neg : v;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;

    logic [7:0]  bin;        // binary bits still to be shifted into bcd
    logic [11:0] bcd;        // {hundreds, tens, ones} being built
    logic [2:0]  iter;       // shifts already performed on this byte
    logic [7:0]  cur_byte;   // byte under conversion, reported on completion
    logic [7:0]  pend_byte;
    logic        pending;

    logic [3:0]  disp_h;
    logic [3:0]  disp_t;
    logic [3:0]  disp_o;

`ifdef SIGNED_DISPLAY_EN
    logic        cur_sign;
    logic        disp_sign;
`endif

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       dig_idx;   // digit that will be driven at the next wrap

    // Control decoded from the FSM
    logic        last_iter;
    logic        start_new;
    logic        pend_wr;
    logic [7:0]  start_byte;

    // Datapath
    logic [11:0] bcd_adj;
    logic [11:0] bcd_step;
    logic [7:0]  bin_step;
    logic        unused_bcd_msb;

    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: stay in CONVERT while there is anything left to convert.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (last_iter && !pending && !load) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag and conversion start / pending-buffer strobes.
    always_comb begin
        busy      = (state == CONVERT);
        last_iter = (state == CONVERT) && (iter == 3'd7);
        // A new conversion starts from IDLE on load, or back-to-back on the
        // completion edge when a byte is pending or arriving right then.
        start_new = ((state == IDLE) && load) ||
                    (last_iter && (pending || load));
        // The pending byte has priority on the completion edge; otherwise
        // the byte on data_in is started directly.
        start_byte = ((state == CONVERT) && pending) ? pend_byte : data_in;
        // Loads while busy go to the pending slot, except a load on the
        // completion edge with nothing pending, which starts at once.
        pend_wr   = load && (state == CONVERT) && !(last_iter && !pending);
    end

    // ------------------------------------------------------------------
    // Double-dabble step
    // ------------------------------------------------------------------

    // One add-3-then-shift iteration on {bcd, bin}.
    always_comb begin
        bcd_adj  = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        bcd_step = {bcd_adj[10:0], bin[7]};
        bin_step = {bin[6:0], 1'b0};
        // The top bit shifts out; it is never set for inputs up to 255.
        unused_bcd_msb = bcd_adj[11];
    end

    // Conversion registers, pending buffer and completed-result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin       <= '0;
            bcd       <= '0;
            iter      <= '0;
            cur_byte  <= '0;
            pend_byte <= '0;
            pending   <= 1'b0;
            value_out <= '0;
            disp_h    <= '0;
            disp_t    <= '0;
            disp_o    <= '0;
`ifdef SIGNED_DISPLAY_EN
            cur_sign  <= 1'b0;
            disp_sign <= 1'b0;
`endif
        end else begin
            if (start_new) begin
`ifdef SIGNED_DISPLAY_EN
                bin      <= magnitude(start_byte);
                cur_sign <= start_byte[7];
`else
                bin      <= start_byte;
`endif
                bcd      <= '0;
                iter     <= '0;
                cur_byte <= start_byte;
            end else if (state == CONVERT) begin
                bin  <= bin_step;
                bcd  <= bcd_step;
                iter <= 3'(iter + 3'd1);
            end

            // The eighth shift lands directly in the display registers.
            if (last_iter) begin
                disp_h    <= bcd_step[11:8];
                disp_t    <= bcd_step[7:4];
                disp_o    <= bcd_step[3:0];
                value_out <= cur_byte;
`ifdef SIGNED_DISPLAY_EN
                disp_sign <= cur_sign;
`endif
            end

            if (pend_wr) begin
                pend_byte <= data_in;
                pending   <= 1'b1;
            end else if (last_iter) begin
                pending   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------

    // Digit enable and segment pattern for the digit selected by dig_idx,
    // with leading-zero blanking on tens and hundreds.
    always_comb begin
        an_nxt = ~(4'b0001 << dig_idx);
        case (dig_idx)
            2'd0: seg_nxt = seg_code(disp_o);
            2'd1: seg_nxt = ((disp_h == 4'd0) && (disp_t == 4'd0)) ?
                            SEG_BLANK : seg_code(disp_t);
            2'd2: seg_nxt = (disp_h == 4'd0) ? SEG_BLANK : seg_code(disp_h);
`ifdef SIGNED_DISPLAY_EN
            default: seg_nxt = disp_sign ? SEG_MINUS : SEG_BLANK;
`else
            default: seg_nxt = SEG_BLANK;
`endif
        endcase
    end

    // Dwell counter; on each wrap drive the selected digit and move on, so
    // the first drive after reset is digit 0 at the REFRESH_DIV-th edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            an       <= 4'b1111;
            seg      <= SEG_BLANK;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= 2'(dig_idx + 2'd1);
            an       <= an_nxt;
            seg      <= seg_nxt;
        end else begin
            scan_cnt <= CNT_W'(scan_cnt + CNT_W'(1));
        end
    end

endmodule

// File: tb/tb_output_display.sv
// Bench for output_display with REFRESH_DIV=4. Stimulus pushes expected
// value_out updates and expected scan drives into queues; two monitors pop
// and compare whenever the DUT updates value_out or drives a new digit.
`timescale 1ns/1ps

module tb_output_display;

    localparam int RD = 4;

    localparam logic [6:0] S0  = 7'b0111111;
    localparam logic [6:0] S1  = 7'b0000110;
    localparam logic [6:0] S2  = 7'b1011011;
    localparam logic [6:0] S3  = 7'b1001111;
    localparam logic [6:0] S4  = 7'b1100110;
    localparam logic [6:0] S5  = 7'b1101101;
    localparam logic [6:0] S6  = 7'b1111101;
    localparam logic [6:0] S7  = 7'b0000111;
    localparam logic [6:0] SBL = 7'b0000000;
    localparam logic [6:0] SMN = 7'b1000000;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data_in;
    logic       busy;
    logic [7:0] value_out;
    logic [6:0] seg;
    logic [3:0] an;

    int n_cmp;
    int n_err;

    logic [7:0]  vo_q[$];
    logic [10:0] disp_q[$];   // {an, seg}

    output_display #(.REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_in   (data_in),
        .busy      (busy),
        .value_out (value_out),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    // Expected scan cycle, in drive order digit 0..3.
    task automatic push_disp(input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0);
        disp_q.push_back({4'b1110, d0});
        disp_q.push_back({4'b1101, d1});
        disp_q.push_back({4'b1011, d2});
        disp_q.push_back({4'b0111, d3});
    endtask

    task automatic wait_disp();
        for (int i = 0; i < 200; i++) begin
            if (disp_q.size() == 0) break;
            @(negedge clk);
        end
        if (disp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scan timeout: %0d drives unseen, required 0", disp_q.size());
            disp_q.delete();
        end
    endtask

    task automatic do_load(input logic [7:0] b);
        @(negedge clk);
        load    = 1'b1;
        data_in = b;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Counts busy cycles, starting at the negedge right after the load edge.
    task automatic measure_busy(output int n);
        n = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    // Monitor: every value_out update must match the next expected result.
    initial begin : vo_mon
        logic [7:0] prev;
        logic [7:0] exp;
        prev = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = value_out;
            end else if (value_out != prev) begin
                prev = value_out;
                if (vo_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL value_out unexpected update: got %0d, required no update", value_out);
                end else begin
                    exp = vo_q.pop_front();
                    check("value_out", int'(value_out), int'(exp));
                end
            end
        end
    end

    // Monitor: once a scan cycle is expected, compare each drive starting
    // from the next digit-0 drive.
    initial begin : disp_mon
        logic [3:0]  prev_an;
        logic [10:0] exp;
        bit          collecting;
        prev_an    = 4'b1111;
        collecting = 1'b0;
        forever begin
            @(negedge clk);
            if (disp_q.size() == 0) collecting = 1'b0;
            if (!rst) begin
                prev_an    = an;
                collecting = 1'b0;
            end else if (an != prev_an) begin
                prev_an = an;
                if (!collecting && disp_q.size() > 0 && an == 4'b1110)
                    collecting = 1'b1;
                if (collecting) begin
                    exp = disp_q.pop_front();
                    check("scan {an,seg}", int'({an, seg}), int'(exp));
                end
            end
        end
    end

    initial begin : stim
        int nb;
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b0;
        load    = 1'b0;
        data_in = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset an", int'(an), 4'b1111);
        check("reset seg", int'(seg), 0);
        check("reset busy", int'(busy), 0);
        check("reset value_out", int'(value_out), 0);
        rst = 1'b1;
        for (int i = 0; i < RD - 1; i++) begin
            @(negedge clk);
            check("pre-drive an", int'(an), 4'b1111);
            check("pre-drive seg", int'(seg), 0);
        end
        @(negedge clk);
        check("first drive an", int'(an), 4'b1110);
        check("first drive seg", int'(seg), int'(S0));
        check("idle busy", int'(busy), 0);

        // 237: three digits
        vo_q.push_back(8'd237);
        do_load(8'd237);
        measure_busy(nb);
        check("busy cycles 237", nb, 8);
        push_disp(SBL, S2, S3, S7);
        wait_disp();

        // 5: leading-zero blanking
        vo_q.push_back(8'd5);
        do_load(8'd5);
        measure_busy(nb);
        check("busy cycles 5", nb, 8);
        push_disp(SBL, SBL, SBL, S5);
        wait_disp();

        // 100, 42, 7 on consecutive edges: 42 is overwritten by 7
        vo_q.push_back(8'd100);
        vo_q.push_back(8'd7);
        @(negedge clk);
        load    = 1'b1;
        data_in = 8'd100;
        nb      = 0;
        @(negedge clk);
        if (busy) nb++;
        data_in = 8'd42;
        @(negedge clk);
        if (busy) nb++;
        data_in = 8'd7;
        @(negedge clk);
        if (busy) nb++;
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
        end
        check("busy cycles 100/42/7", nb, 16);
        push_disp(SBL, SBL, SBL, S7);
        wait_disp();

        // 8'hF6
        vo_q.push_back(8'hF6);
        do_load(8'hF6);
        measure_busy(nb);
        check("busy cycles F6", nb, 8);
`ifdef SIGNED_DISPLAY_EN
        push_disp(SMN, SBL, S1, S0);
`else
        push_disp(SBL, S2, S4, S6);
`endif
        wait_disp();

        // Reset during the 4th CONVERT cycle with a byte pending
        @(negedge clk);
        load    = 1'b1;
        data_in = 8'd55;
        @(negedge clk);
        data_in = 8'd99;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("busy before abort", int'(busy), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort an", int'(an), 4'b1111);
        check("abort seg", int'(seg), 0);
        check("abort value_out", int'(value_out), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        push_disp(SBL, SBL, SBL, S0);
        wait_disp();
        repeat (20) @(negedge clk);
        check("post-abort value_out", int'(value_out), 0);
        check("post-abort busy", int'(busy), 0);

        check("value_out queue drained", vo_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
